// File: rtl/nsa_pkg.sv
// ---------------------------------------------------------------------------
// nsa_pkg
// Shared definitions for the nibble-serial adder.
//   NIB_W        : datapath slice width (one nibble)
//   nsa_state_t  : controller states IDLE / RUN / DONE
//   nib_cnt()    : number of nibbles in an operand of the given width
//   cnt_w()      : bit width of the nibble counter for the given operand width
// ---------------------------------------------------------------------------
package nsa_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } nsa_state_t;

    function automatic int nib_cnt(input int width);
        return width / NIB_W;
    endfunction

    // Operands are at least two nibbles wide, so $clog2 never returns 0 here;
    // the guard only protects against misuse with a single-nibble width.
    function automatic int cnt_w(input int width);
        return (nib_cnt(width) > 1) ? $clog2(nib_cnt(width)) : 1;
    endfunction

endpackage

// File: rtl/nibble_add4.sv
// ---------------------------------------------------------------------------
// nibble_add4
// Combinational 4-bit adder: {co, s4} = x4 + y4 + ci.
// Ports:
//   x4, y4 : in  [3:0] addend nibbles
//   ci     : in        carry in
//   s4     : out [3:0] sum nibble
//   co     : out       carry out of bit 3
// ---------------------------------------------------------------------------
module nibble_add4
    import nsa_pkg::*;
(
    input  logic [NIB_W-1:0] x4,
    input  logic [NIB_W-1:0] y4,
    input  logic             ci,
    output logic [NIB_W-1:0] s4,
    output logic             co
);

    logic [NIB_W:0] c_chain;

    assign c_chain[0] = ci;

    // Plain ripple chain; one full adder per bit.
    generate
        for (genvar gi = 0; gi < NIB_W; gi++) begin : g_fa
            assign s4[gi]        = x4[gi] ^ y4[gi] ^ c_chain[gi];
            assign c_chain[gi+1] = (x4[gi] & y4[gi]) | (c_chain[gi] & (x4[gi] ^ y4[gi]));
        end
    endgenerate

    assign co = c_chain[NIB_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder
// Sequential WIDTH-bit adder processing one nibble per clock, LSB nibble
// first, with the inter-nibble carry held in a register.
//   {c_out, s} = a + b + c_in   (modulo 2^(WIDTH+1))
// Optional feature macro: SUB_EN -- adds the `sub` port; sub=1 at accept
// computes a - b (b inverted, carry forced to 1, c_in ignored); c_out=1
// then means "no borrow".
// Ports:
//   clk       : in         rising-edge clock
//   rst_n     : in         asynchronous active-low reset
//   in_valid  : in         operands presented
//   in_ready  : out        operands accepted (high only in IDLE)
//   a, b      : in  WIDTH  operands
//   c_in      : in         carry in
//   sub       : in         subtract select (SUB_EN builds only)
//   out_valid : out        result valid (DONE)
//   out_ready : in         consumer accepts result
//   s         : out WIDTH  sum; keeps last result until the next op runs
//   c_out     : out        carry out of bit WIDTH-1
//   busy      : out        high in RUN or DONE
// WIDTH must be a multiple of 4 and at least 8.
// ---------------------------------------------------------------------------
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             busy
);

    localparam int NIB   = nib_cnt(WIDTH);
    localparam int CNT_W = cnt_w(WIDTH);

    nsa_state_t       state_reg,  state_next;
    logic [WIDTH-1:0] a_sh_reg,   a_sh_next;
    logic [WIDTH-1:0] b_sh_reg,   b_sh_next;
    logic [WIDTH-1:0] s_reg,      s_next;
    logic             carry_reg,  carry_next;
    logic             c_out_reg,  c_out_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;

    logic [NIB_W-1:0] sum_nib;
    logic             nib_co;

    // The single nibble adder always looks at the low nibble of the shifters.
    nibble_add4 u_add4 (
        .x4 (a_sh_reg[NIB_W-1:0]),
        .y4 (b_sh_reg[NIB_W-1:0]),
        .ci (carry_reg),
        .s4 (sum_nib),
        .co (nib_co)
    );

    always_comb begin
        state_next = state_reg;
        a_sh_next  = a_sh_reg;
        b_sh_next  = b_sh_reg;
        s_next     = s_reg;
        carry_next = carry_reg;
        c_out_next = c_out_reg;
        cnt_next   = cnt_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    a_sh_next  = a;
                    b_sh_next  = b;
                    carry_next = c_in;
`ifdef SUB_EN
                    // Two's-complement subtract: a + ~b + 1.
                    if (sub) begin
                        b_sh_next  = ~b;
                        carry_next = 1'b1;
                    end
`endif
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                // After NIB shifts the first nibble computed lands in s[3:0].
                s_next     = {sum_nib, s_reg[WIDTH-1:NIB_W]};
                a_sh_next  = a_sh_reg >> NIB_W;
                b_sh_next  = b_sh_reg >> NIB_W;
                carry_next = nib_co;
                cnt_next   = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(NIB - 1)) begin
                    c_out_next = nib_co;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            s_reg     <= '0;
            carry_reg <= 1'b0;
            c_out_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            a_sh_reg  <= a_sh_next;
            b_sh_reg  <= b_sh_next;
            s_reg     <= s_next;
            carry_reg <= carry_next;
            c_out_reg <= c_out_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign s         = s_reg;
    assign c_out     = c_out_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_adder
// Directed bench for nibble_serial_adder (WIDTH=16). A transaction-level
// model (plain arithmetic plus a latency countdown) predicts the handshake
// outputs and the result; a compare process checks it every negedge.
// Hand-computed literals pin the model on the directed vectors.
// Define SUB_EN to exercise the subtract vectors.
// ---------------------------------------------------------------------------
module tb_nibble_serial_adder;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          c_in;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  s;
    logic          c_out;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
`ifdef SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .c_out     (c_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    int           m_left = 0;
    logic [W:0]   m_pend = '0;
    logic [W-1:0] m_s    = '0;
    logic         m_c    = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_left = 0;
            m_s    = '0;
            m_c    = 1'b0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1'b1;
                m_left = NIB;
                m_pend = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};
`ifdef SUB_EN
                if (sub) m_pend = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
`endif
            end
        end else if (!m_done) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_done = 1'b1;
                m_s    = m_pend[W-1:0];
                m_c    = m_pend[W];
            end
        end else if (out_ready) begin
            m_busy = 1'b0;
            m_done = 1'b0;
        end
    end

    // Result outputs are meaningful while idle (last result held) or in DONE.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cmp_in_ready",  {31'd0, in_ready},  {31'd0, !m_busy});
            chk("cmp_out_valid", {31'd0, out_valid}, {31'd0, m_done});
            chk("cmp_busy",      {31'd0, busy},      {31'd0, m_busy});
            if (!m_busy || m_done) begin
                chk("cmp_s",     {16'd0, s},         {16'd0, m_s});
                chk("cmp_c_out", {31'd0, c_out},     {31'd0, m_c});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                            input logic tc, input logic tsub, input logic early_rdy);
        int k;
        a = ta; b = tb_v; c_in = tc; sub = tsub; in_valid = 1'b1;
        out_ready = early_rdy;
        k = 0;
        while (!in_ready && k < 20) begin
            step();
            k++;
        end
        if (k >= 20) chk("accept_timeout", 32'd1, 32'd0);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        if (lat >= 20) chk("valid_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tc, input logic tsub, input logic early_rdy,
                         output logic [W-1:0] rs, output logic rc);
        int lat;
        start_op(ta, tb_v, tc, tsub, early_rdy);
        wait_valid(lat);
        chk("latency", lat, NIB);
        rs = s;
        rc = c_out;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        $display("op a=%h b=%h c_in=%0d sub=%0d -> s=%h c_out=%0d latency=%0d",
                 ta, tb_v, tc, tsub, rs, rc, lat);
    endtask

    logic [W-1:0] rs;
    logic         rc;
    int           lat;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c_in = 1'b0; sub = 1'b0;

        // 1. Reset state
        step(); step();
        rst_n = 1'b1;
        step();
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_s",         {16'd0, s},         32'd0);
        chk("rst_c_out",     {31'd0, c_out},     32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);

        // 2. Plain add, no carries
        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, rs, rc);
        chk("t2_s", {16'd0, rs}, 32'h5555);
        chk("t2_c", {31'd0, rc}, 32'd0);

        // 3. Carry ripples across every nibble; out_ready held high during RUN
        do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, rs, rc);
        chk("t3_s", {16'd0, rs}, 32'h0000);
        chk("t3_c", {31'd0, rc}, 32'd1);

        // 4. Backpressure in DONE with new operands offered
        start_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
        wait_valid(lat);
        chk("t4_latency", lat, NIB);
        a = 16'hAAAA; b = 16'hBBBB; c_in = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_hold_s",     {16'd0, s},         32'h5555);
            chk("t4_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t4_hold_ready", {31'd0, in_ready},  32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t4_idle_ready", {31'd0, in_ready},  32'd1);
        chk("t4_idle_valid", {31'd0, out_valid}, 32'd0);
        chk("t4_idle_s",     {16'd0, s},         32'h5555);
        $display("op backpressure hold s=%h in_ready=%0d", s, in_ready);

        // 5. Reset mid-RUN, then a fresh op
        start_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
        step();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_rst_ready", {31'd0, in_ready},  32'd1);
        chk("t5_rst_busy",  {31'd0, busy},      32'd0);
        chk("t5_rst_s",     {16'd0, s},         32'd0);
        step();
        rst_n = 1'b1;
        step();
        $display("op reset mid-run in_ready=%0d out_valid=%0d", in_ready, out_valid);
        do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, rs, rc);
        chk("t5_s", {16'd0, rs}, 32'h0100);
        chk("t5_c", {31'd0, rc}, 32'd0);

`ifdef SUB_EN
        // 6. Subtract
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, rs, rc);
        chk("t6a_s", {16'd0, rs}, 32'hFFFE);
        chk("t6a_c", {31'd0, rc}, 32'd0);
        do_op(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b0, rs, rc);
        chk("t6b_s", {16'd0, rs}, 32'h0002);
        chk("t6b_c", {31'd0, rc}, 32'd1);
`endif

        // Back-to-back ops to finish with a sum exercising mixed carries
        do_op(16'h8F7E, 16'h70C3, 1'b0, 1'b0, 1'b0, rs, rc);
        chk("t7_s", {16'd0, rs}, 32'h0041);
        chk("t7_c", {31'd0, rc}, 32'd1);

        step();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
